// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Op codes follow the RV32M funct3 encoding directly.
package muldiv_pkg;

    localparam int          MD_ITER = 32;
    localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } md_state_t;

    function automatic logic is_div(input md_op_t op);
        return op[2];
    endfunction

    function automatic logic is_rem(input md_op_t op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_signed_a(input md_op_t op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic is_signed_b(input md_op_t op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit per step.
// The hi/lo register pair holds {product} for multiply and {remainder, dividend/quotient} for divide.
module md_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            div_mode,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] product_hi,
    output logic [XLEN-1:0] product_lo,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opd;
    logic            r_div;

    logic [XLEN:0]   w_madd;
    logic [XLEN:0]   w_rsh;
    logic            w_ge;
    logic [XLEN-1:0] w_rsub;
    logic [XLEN-1:0] w_nxt_hi;
    logic [XLEN-1:0] w_nxt_lo;

    assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
    // Guard bit is w_rsh[XLEN]; when the trial subtract succeeds the difference fits in XLEN bits.
    assign w_rsh  = {r_hi, r_lo[XLEN-1]};
    assign w_ge   = (w_rsh >= {1'b0, r_opd});
    assign w_rsub = w_rsh[XLEN-1:0] - r_opd;

    always_comb begin
        w_nxt_hi = r_hi;
        w_nxt_lo = r_lo;
        if (step) begin
            if (r_div) begin
                w_nxt_hi = w_ge ? w_rsub : w_rsh[XLEN-1:0];
                w_nxt_lo = {r_lo[XLEN-2:0], w_ge};
            end else begin
                w_nxt_hi = w_madd[XLEN:1];
                w_nxt_lo = {w_madd[0], r_lo[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_opd <= '0;
            r_div <= 1'b0;
        end else if (load) begin
            r_hi  <= '0;
            r_lo  <= a_mag;
            r_opd <= b_mag;
            r_div <= div_mode;
        end else begin
            r_hi  <= w_nxt_hi;
            r_lo  <= w_nxt_lo;
        end
    end

    // Outputs show the post-step values so the final step's result is usable on the same edge.
    assign product_hi = w_nxt_hi;
    assign product_lo = w_nxt_lo;
    assign quotient   = w_nxt_lo;
    assign remainder  = w_nxt_hi;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: start/busy/done FSM, special-case fast path and sign fix-up
// around an unsigned 32-step iterative core.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      MdOp,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] MdResult
);

    md_state_t       r_state;
    md_op_t          r_op;
    logic [4:0]      r_count;
    logic            r_neg;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    md_op_t          w_op;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div0;
    logic            w_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;
    logic            w_load;
    logic            w_step;
    logic            w_last;
    logic [XLEN-1:0] w_p_hi;
    logic [XLEN-1:0] w_p_lo;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0] w_final;

    assign w_op       = md_op_t'(MdOp);
    assign w_a_neg    = is_signed_a(w_op) & A[XLEN-1];
    assign w_b_neg    = is_signed_b(w_op) & B[XLEN-1];
    assign w_a_mag    = w_a_neg ? -A : A;
    assign w_b_mag    = w_b_neg ? -B : B;
    assign w_div0     = is_div(w_op) && (B == '0);
    assign w_ovf      = ((w_op == MD_DIV) || (w_op == MD_REM)) && (A == INT_MIN) && (B == '1);
    assign w_fast     = w_div0 || w_ovf;
    assign w_fast_res = w_div0 ? (is_rem(w_op) ? A : DIV0_Q)
                               : (is_rem(w_op) ? '0 : INT_MIN);
    assign w_load     = start && (r_state != CALC) && !w_fast;
    assign w_step     = (r_state == CALC);
    assign w_last     = (r_count == 5'(MD_ITER - 1));

    md_iter_core #(.XLEN(XLEN)) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load),
        .step       (w_step),
        .div_mode   (is_div(w_op)),
        .a_mag      (w_a_mag),
        .b_mag      (w_b_mag),
        .product_hi (w_p_hi),
        .product_lo (w_p_lo),
        .quotient   (w_quo),
        .remainder  (w_rem)
    );

    assign w_prod_s = r_neg ? -{w_p_hi, w_p_lo} : {w_p_hi, w_p_lo};

    always_comb begin
        w_final = '0;
        case (r_op)
            MD_MUL:                       w_final = w_prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              w_final = r_neg ? -w_quo : w_quo;
            default:                      w_final = r_neg ? -w_rem : w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= MD_MUL;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_op    <= w_op;
                        r_neg   <= is_rem(w_op) ? w_a_neg : (w_a_neg ^ w_b_neg);
                        r_count <= '0;
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= CALC;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_count <= r_count + 5'd1;
                    if (w_last) begin
                        r_result <= w_final;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign MdResult = r_result;

endmodule
